mnist_accuracy_monitor: RTL and testbench

Synthesizable on-chip scoreboard that sits directly downstream of the DNN output layer. Each block cycle it collects the serial ideal-output chunks (`y_out`) and compares them against the thresholded network outputs (`a_out_alln`). It keeps a sliding-window correct count, a running total, and case and epoch counters, and drives the training-case select (`sel_tc`) back to the upstream input mux. This replaces the simulation-only accuracy bookkeeping with hardware that can run on FPGA.

---
 rtl/mnist_accuracy_monitor.sv | 167 ++++++++++++++++
 tb/tb_mnist_accuracy_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mnist_accuracy_monitor.sv
// Hardware accuracy scoreboard for the DNN output layer: captures the serial ideal
// output, compares it with the thresholded outputs once per block cycle, keeps the counters.
module mnist_accuracy_monitor #(
    parameter int n_out                = 16,
    parameter int y_chunk              = 1,
    parameter int cpc                  = 18,
    parameter int checklast            = 1000,
    parameter int training_cases       = 10000,
    parameter int total_training_cases = 100000
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(cpc)-1:0]               cycle_index,
    input  logic [y_chunk-1:0]                   y_out,
    input  logic [n_out-1:0]                     a_out_alln,
    output logic [$clog2(training_cases)-1:0]    sel_tc,
    output logic                                 result_valid,
    output logic                                 correct,
    output logic [$clog2(checklast+1)-1:0]       recent,
    output logic [31:0]                          total_correct,
    output logic [31:0]                          num_train,
    output logic [15:0]                          epoch,
    output logic                                 epoch_done,
    output logic                                 done
);

    localparam int CI_W   = $clog2(cpc);
    localparam int TC_W   = $clog2(training_cases);
    localparam int R_W    = $clog2(checklast + 1);
    localparam int P_W    = (checklast > 1) ? $clog2(checklast) : 1;
    localparam int NCHUNK = n_out / y_chunk;

    localparam logic [CI_W-1:0] CI_ZERO = CI_W'(0);
    localparam logic [CI_W-1:0] CI_LAST = CI_W'(cpc - 1);
    localparam logic [TC_W-1:0] SEL_MAX = TC_W'(training_cases - 1);
    localparam logic [P_W-1:0]  PT_MAX  = P_W'(checklast - 1);
    localparam logic [31:0]     N_DONE  = 32'(total_training_cases);

    logic [n_out-1:0]     ideal_q, ideal_d;
    logic                 primed_q, primed_d;
    logic [checklast-1:0] win_q, win_d;
    logic [P_W-1:0]       crt_pt_q, crt_pt_d;
    logic [TC_W-1:0]      sel_tc_q, sel_tc_d;
    logic                 result_valid_q, result_valid_d;
    logic                 correct_q, correct_d;
    logic [R_W-1:0]       recent_q, recent_d;
    logic [31:0]          total_correct_q, total_correct_d;
    logic [31:0]          num_train_q, num_train_d;
    logic [15:0]          epoch_q, epoch_d;
    logic                 epoch_done_q, epoch_done_d;
    logic                 done_q, done_d;

    logic eval_s;
    logic match_s;
    logic old_s;
    logic sel_wrap_s;
    logic pt_wrap_s;

    assign eval_s     = (cycle_index == CI_ZERO) && primed_q && !done_q;
    assign match_s    = (a_out_alln == ideal_q);
    assign old_s      = win_q[crt_pt_q];
    assign sel_wrap_s = (sel_tc_q == SEL_MAX);
    assign pt_wrap_s  = (crt_pt_q == PT_MAX);

    // Capture, priming and the per-case evaluation update.
    always_comb begin
        ideal_d         = ideal_q;
        primed_d        = primed_q;
        win_d           = win_q;
        crt_pt_d        = crt_pt_q;
        sel_tc_d        = sel_tc_q;
        result_valid_d  = 1'b0;
        correct_d       = correct_q;
        recent_d        = recent_q;
        total_correct_d = total_correct_q;
        num_train_d     = num_train_q;
        epoch_d         = epoch_q;
        epoch_done_d    = 1'b0;
        done_d          = done_q;

        // Chunk k of the ideal vector arrives at cycle_index k+2.
        for (int k = 0; k < NCHUNK; k++) begin
            if (cycle_index == CI_W'(k + 2)) begin
                ideal_d[k*y_chunk +: y_chunk] = y_out;
            end else begin
                ideal_d[k*y_chunk +: y_chunk] = ideal_d[k*y_chunk +: y_chunk];
            end
        end

        if (cycle_index == CI_LAST) begin
            primed_d = 1'b1;
        end else begin
            primed_d = primed_q;
        end

        if (eval_s) begin
            primed_d        = 1'b0;
            correct_d       = match_s;
            result_valid_d  = 1'b1;
            win_d[crt_pt_q] = match_s;
            recent_d        = recent_q - R_W'(old_s) + R_W'(match_s);
            crt_pt_d        = pt_wrap_s ? P_W'(0) : crt_pt_q + P_W'(1);
            total_correct_d = total_correct_q + 32'(match_s);
            num_train_d     = num_train_q + 32'd1;
            if (sel_wrap_s) begin
                sel_tc_d     = TC_W'(0);
                epoch_d      = epoch_q + 16'd1;
                epoch_done_d = 1'b1;
            end else begin
                sel_tc_d     = sel_tc_q + TC_W'(1);
                epoch_d      = epoch_q;
                epoch_done_d = 1'b0;
            end
            if (num_train_d == N_DONE) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end else begin
            result_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ideal_q         <= '0;
            primed_q        <= 1'b0;
            win_q           <= '0;
            crt_pt_q        <= '0;
            sel_tc_q        <= '0;
            result_valid_q  <= 1'b0;
            correct_q       <= 1'b0;
            recent_q        <= '0;
            total_correct_q <= 32'd0;
            num_train_q     <= 32'd0;
            epoch_q         <= 16'd1;
            epoch_done_q    <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            ideal_q         <= ideal_d;
            primed_q        <= primed_d;
            win_q           <= win_d;
            crt_pt_q        <= crt_pt_d;
            sel_tc_q        <= sel_tc_d;
            result_valid_q  <= result_valid_d;
            correct_q       <= correct_d;
            recent_q        <= recent_d;
            total_correct_q <= total_correct_d;
            num_train_q     <= num_train_d;
            epoch_q         <= epoch_d;
            epoch_done_q    <= epoch_done_d;
            done_q          <= done_d;
        end
    end

    assign sel_tc        = sel_tc_q;
    assign result_valid  = result_valid_q;
    assign correct       = correct_q;
    assign recent        = recent_q;
    assign total_correct = total_correct_q;
    assign num_train     = num_train_q;
    assign epoch         = epoch_q;
    assign epoch_done    = epoch_done_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mnist_accuracy_monitor.sv
// Scoreboard bench for mnist_accuracy_monitor: directed cases push hand-computed
// expectations, a negedge monitor pops and compares on every result_valid.
module tb_mnist_accuracy_monitor;

    localparam int N_OUT     = 16;
    localparam int Y_CHUNK   = 1;
    localparam int CPC       = 18;
    localparam int CHECKLAST = 4;
    localparam int TC        = 3;
    localparam int TOTAL     = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  cycle_index;
    logic [0:0]  y_out;
    logic [15:0] a_out_alln;
    logic [1:0]  sel_tc;
    logic        result_valid;
    logic        correct;
    logic [2:0]  recent;
    logic [31:0] total_correct;
    logic [31:0] num_train;
    logic [15:0] epoch;
    logic        epoch_done;
    logic        done;

    mnist_accuracy_monitor #(
        .n_out(N_OUT), .y_chunk(Y_CHUNK), .cpc(CPC), .checklast(CHECKLAST),
        .training_cases(TC), .total_training_cases(TOTAL)
    ) dut (
        .clk(clk), .reset(reset), .cycle_index(cycle_index), .y_out(y_out),
        .a_out_alln(a_out_alln), .sel_tc(sel_tc), .result_valid(result_valid),
        .correct(correct), .recent(recent), .total_correct(total_correct),
        .num_train(num_train), .epoch(epoch), .epoch_done(epoch_done), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic c;
        int   rec;
        int   tot;
        int   num;
        int   sel;
        int   ep;
        logic ed;
        logic dn;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every presented result against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (result_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result_valid: got 1 expected 0 (num_train=%0d)", num_train);
            end else begin
                e = sb_q.pop_front();
                chk("correct",       32'(correct),    32'(e.c));
                chk("recent",        32'(recent),     32'(e.rec));
                chk("total_correct", total_correct,   32'(e.tot));
                chk("num_train",     num_train,       32'(e.num));
                chk("sel_tc",        32'(sel_tc),     32'(e.sel));
                chk("epoch",         32'(epoch),      32'(e.ep));
                chk("epoch_done",    32'(epoch_done), 32'(e.ed));
                chk("done",          32'(done),       32'(e.dn));
            end
        end else if (epoch_done !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL stray_epoch_done: got %b expected 0", epoch_done);
        end
    end

    task automatic drive_ci(input int ci, input logic yb, input logic [15:0] a);
        cycle_index = 5'(ci);
        y_out       = yb;
        a_out_alln  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [15:0] ideal, input logic [15:0] a);
        for (int ci = 2; ci < CPC; ci++) begin
            drive_ci(ci, ideal[ci-2], a);
        end
    endtask

    task automatic run_case(input logic [15:0] ideal, input logic [15:0] a, input exp_t e);
        capture(ideal, a);
        sb_q.push_back(e);
        drive_ci(0, 1'b0, a);
        drive_ci(1, 1'b0, a);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_sel_tc"},        32'(sel_tc),       32'd0);
        chk({tag, "_result_valid"},  32'(result_valid), 32'd0);
        chk({tag, "_correct"},       32'(correct),      32'd0);
        chk({tag, "_recent"},        32'(recent),       32'd0);
        chk({tag, "_total_correct"}, total_correct,     32'd0);
        chk({tag, "_num_train"},     num_train,         32'd0);
        chk({tag, "_epoch"},         32'(epoch),        32'd1);
        chk({tag, "_epoch_done"},    32'(epoch_done),   32'd0);
        chk({tag, "_done"},          32'(done),         32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        cycle_index = 5'd0;
        y_out       = 1'b0;
        a_out_alln  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        reset = 1'b0;

        // First block after reset is unprimed: no result expected.
        drive_ci(0, 1'b0, 16'h0000);
        drive_ci(1, 1'b0, 16'h0000);

        // Correct case.
        run_case(16'h0008, 16'h0008, '{1'b1, 1, 1, 1, 1, 1, 1'b0, 1'b0});

        // Fully primed block, then reset before its evaluating edge.
        capture(16'hA5C3, 16'hA5C3);
        cycle_index = 5'd0;
        reset       = 1'b1;
        #1;
        check_reset("mid");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_ci(0, 1'b0, 16'hA5C3);
        drive_ci(1, 1'b0, 16'hA5C3);

        // Single-bit mismatch.
        run_case(16'h0008, 16'h0009, '{1'b0, 0, 0, 1, 1, 1, 1'b0, 1'b0});

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_ci(0, 1'b0, 16'h0000);
        drive_ci(1, 1'b0, 16'h0000);

        // Window eviction 1,1,0,1,0,0 with epoch wraps after cases 3 and 6; done on case 6.
        run_case(16'h8001, 16'h8001, '{1'b1, 1, 1, 1, 1, 1, 1'b0, 1'b0});
        run_case(16'h1234, 16'h1234, '{1'b1, 2, 2, 2, 2, 1, 1'b0, 1'b0});
        run_case(16'hFFFF, 16'h7FFF, '{1'b0, 2, 2, 3, 0, 2, 1'b1, 1'b0});
        run_case(16'h0F0F, 16'h0F0F, '{1'b1, 3, 3, 4, 1, 2, 1'b0, 1'b0});
        run_case(16'hC3A5, 16'hC3A4, '{1'b0, 2, 3, 5, 2, 2, 1'b0, 1'b0});
        run_case(16'h0000, 16'h0100, '{1'b0, 1, 3, 6, 0, 3, 1'b1, 1'b1});

        // After done: further blocks must produce nothing and counters hold.
        for (int b = 0; b < 2; b++) begin
            capture(16'h5555, 16'h5555);
            drive_ci(0, 1'b0, 16'h5555);
            drive_ci(1, 1'b0, 16'h5555);
        end
        chk("hold_num_train",     num_train,         32'd6);
        chk("hold_done",          32'(done),         32'd1);
        chk("hold_sel_tc",        32'(sel_tc),       32'd0);
        chk("hold_epoch",         32'(epoch),        32'd3);
        chk("hold_total_correct", total_correct,     32'd3);
        chk("hold_recent",        32'(recent),       32'd1);
        chk("scoreboard_empty",   32'(sb_q.size()),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
